// File: rtl/demux_1to8_bit.sv
// demux_1to8_bit
// Registered 1-to-8 demultiplexer. A data bit and a 3-bit address are captured
// together on a rising clk edge when en is high. The registered bit is then
// steered onto outp[adr_q]. All other lines sit at the inactive level.
// Because outp is decoded only from registers, there is no input-to-output
// combinational path and no intermediate selection glitch when inp and adr
// change together.
//
// Build option: define DEMUX1TO8BIT_TRISTATE_EN to make the unselected lines
// drive 1'bz instead of 0. In that build all eight lines also drive Z while
// rst_n is low, so a block held in reset cannot contend the shared row bus.
// The default build (macro undefined) never produces Z.

module demux_1to8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       inp,
    input  logic [2:0] adr,
    output logic [7:0] outp,
    output logic [2:0] adr_q
);

    logic       d_q;
    logic       d_d;
    logic [2:0] adr_d;
    logic [7:0] sel;

    // Next-state: load a new bit/address pair when enabled, otherwise hold.
    always_comb begin
        d_d   = d_q;
        adr_d = adr_q;
        if (en) begin
            d_d   = inp;
            adr_d = adr;
        end
    end

    // Data and address registers, cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= 1'b0;
            adr_q <= 3'b000;
        end else begin
            d_q   <= d_d;
            adr_q <= adr_d;
        end
    end

    // One-hot line select decoded from the registered address.
    always_comb begin
        sel = 8'b0000_0001 << adr_q;
    end

`ifdef DEMUX1TO8BIT_TRISTATE_EN
    // Output drive: the selected line carries d_q and the others float.
    // Reset floats every line regardless of the register contents.
    always_comb begin
        outp = 8'bzzzz_zzzz;
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (sel[i]) begin
                    outp[i] = d_q;
                end
            end
        end
    end
`else
    // Output drive: the selected line carries d_q and the others are held at 0.
    // Reset clears d_q, so outp is all zeros without a separate term.
    always_comb begin
        outp = sel & {8{d_q}};
    end
`endif

endmodule

// File: tb/tb_demux_1to8_bit.sv
// Self-checking bench for demux_1to8_bit. It uses a directed vector table plus
// hand-written reset sequences. The expected outp values are written for the
// default build. When the tristate build is selected, they are mapped to the
// tristate form: the selected line keeps its value and the other lines are Z.

module tb_demux_1to8_bit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       inp;
    logic [2:0] adr;
    logic [7:0] outp;
    logic [2:0] adr_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       inp;
        logic [2:0] adr;
        logic [7:0] exp_o;
        logic [2:0] exp_a;
    } vec_t;

    vec_t vecs[$];

    demux_1to8_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inp   (inp),
        .adr   (adr),
        .outp  (outp),
        .adr_q (adr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] map_out(input logic [7:0] o, input logic [2:0] a);
        logic [7:0] r;
`ifdef DEMUX1TO8BIT_TRISTATE_EN
        r = 8'bzzzz_zzzz;
        r[a] = o[a];
`else
        r = o;
`endif
        return r;
    endfunction

    function automatic logic [7:0] reset_out();
`ifdef DEMUX1TO8BIT_TRISTATE_EN
        return 8'bzzzz_zzzz;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] exp_o, input logic [2:0] exp_a);
        checks++;
        if (outp !== exp_o || adr_q !== exp_a) begin
            errors++;
            $display("FAIL %s: outp=%b adr_q=%0d, required outp=%b adr_q=%0d",
                     name, outp, adr_q, exp_o, exp_a);
        end
    endtask

    task automatic drive(input logic e, input logic d, input logic [2:0] a);
        @(negedge clk);
        en  = e;
        inp = d;
        adr = a;
    endtask

    task automatic add(input logic e, input logic d, input logic [2:0] a,
                       input logic [7:0] o, input logic [2:0] q);
        vec_t v;
        v.en = e; v.inp = d; v.adr = a; v.exp_o = o; v.exp_a = q;
        vecs.push_back(v);
    endtask

    initial begin
        // Walk: outp one-hot follows adr with one edge of latency.
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 1'b1, 3'(i), 8'h01 << i, 3'(i));
        end
        // Data low on the selected line 7.
        add(1'b1, 1'b0, 3'd7, 8'h00, 3'd7);
        // Hold: load line 3, then keep en low while the inputs change.
        add(1'b1, 1'b1, 3'd3, 8'h08, 3'd3);
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b0, 3'd6, 8'h08, 3'd3);
        end
        // Simultaneous inp/adr changes.
        add(1'b1, 1'b0, 3'd1, 8'h00, 3'd1);
        add(1'b1, 1'b1, 3'd5, 8'h20, 3'd5);
        add(1'b1, 1'b1, 3'd0, 8'h01, 3'd0);
        // Set up 8'h40 ahead of the async reset test.
        add(1'b1, 1'b1, 3'd6, 8'h40, 3'd6);

        // Reset held with inputs active and the clock running.
        rst_n = 1'b0;
        en    = 1'b1;
        inp   = 1'b1;
        adr   = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", reset_out(), 3'd0);

        // Release between edges. The first edge loads adr 5.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_before_edge", map_out(8'h00, 3'd0), 3'd0);
        @(posedge clk);
        #1;
        check("first_load", map_out(8'h20, 3'd5), 3'd5);

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].inp, vecs[k].adr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), map_out(vecs[k].exp_o, vecs[k].exp_a), vecs[k].exp_a);
        end

        // Async reset mid-run: outputs clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", reset_out(), 3'd0);
        @(negedge clk);
        check("async_reset_held", reset_out(), 3'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        inp   = 1'b1;
        adr   = 3'd2;
        @(posedge clk);
        #1;
        check("after_async_reset_load", map_out(8'h04, 3'd2), 3'd2);
        drive(1'b1, 1'b0, 3'd2);
        @(posedge clk);
        #1;
        check("selected_low", map_out(8'h00, 3'd2), 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
